// File: rtl/il_pkg.sv
// +----------------------------------------------------------------------------+
// | il_pkg                                                                     |
// | Shared FSM state type, phase encoding and bit-reverse helper for the       |
// | sub-block interleaver address generator.                                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package il_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DUMMY = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] c_ph_idle  = 2'd0;
  localparam logic [1:0] c_ph_dummy = 2'd1;
  localparam logic [1:0] c_ph_write = 2'd2;
  localparam logic [1:0] c_ph_read  = 2'd3;

  localparam int c_max_col_w = 6;

  // Reverse the low w bits of v: reverse all six, then drop the unused low end.
  function automatic logic [c_max_col_w-1:0] bitrev(input logic [c_max_col_w-1:0] v,
                                                    input int w);
    logic [c_max_col_w-1:0] r;
    for (int i = 0; i < c_max_col_w; i++) begin
      r[i] = v[c_max_col_w-1-i];
    end
    return r >> (c_max_col_w - w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/il_read_addr.sv
// +----------------------------------------------------------------------------+
// | il_read_addr                                                               |
// | Column-major read address: bitrev(col) + COLS*row + mode, mod K_pi.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module il_read_addr
  import il_pkg::*;
#(
  parameter int COLS   = 32,
  parameter int ADDR_W = 12,
  parameter int ROWS_W = 7,
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic [COL_W-1:0]  col,
  input  logic [ROWS_W-1:0] row,
  input  logic              mode,
  input  logic [ADDR_W:0]   k_pi,
  output logic [ADDR_W-1:0] addr
);

  localparam int SW = ADDR_W + 1;

  logic [c_max_col_w-1:0] w_rev_full;
  logic [COL_W-1:0]       w_rev;
  logic [SW-1:0]          w_base;
  logic [SW-1:0]          w_sum;

  assign w_rev_full = bitrev(c_max_col_w'(col), COL_W);
  assign w_rev      = w_rev_full[COL_W-1:0];
  assign w_base     = SW'(w_rev) + (SW'(row) << COL_W);

  // base < K_pi, so a single conditional subtract is a full modulo
  assign w_sum = w_base + SW'(mode);
  assign addr  = (w_sum >= k_pi) ? ADDR_W'(w_sum - k_pi) : ADDR_W'(w_sum);

endmodule

`default_nettype wire

// File: rtl/subblock_interleaver_addr_gen.sv
// +----------------------------------------------------------------------------+
// | subblock_interleaver_addr_gen                                              |
// | Generates DUMMY/WRITE/READ RAM addresses for a sub-block interleaver.      |
// | Optional IL_SKIP_DUMMY_EN: READ positions holding dummies are skipped.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module subblock_interleaver_addr_gen
  import il_pkg::*;
#(
  parameter int COLS   = 32,
  parameter int ADDR_W = 12,
  parameter int ROWS_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] d_len,
  input  logic [ROWS_W-1:0] rows,
  input  logic              mode,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [1:0]        phase,
  output logic              is_dummy,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int COL_W = $clog2(COLS);
  localparam int KW    = ADDR_W + 1;
  localparam int FW    = ROWS_W + COL_W;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic [COL_W-1:0]    r_col, w_col_nxt;
  logic [ROWS_W-1:0]   r_row, w_row_nxt;
  logic [KW-1:0]       r_k, r_nd;
  logic [ROWS_W-1:0]   r_rows;
  logic                r_mode, r_err;

  logic [FW-1:0]       w_k_full;
  logic [63:0]         w_k64;
  logic                w_reject;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_rd_dummy;
  logic                w_adv;

  assign w_k_full = {rows, {COL_W{1'b0}}};
  assign w_k64    = 64'(w_k_full);
  // A frame larger than the address space is rejected as well.
  assign w_reject = (rows == '0) || (d_len == '0) || (64'(d_len) > w_k64) ||
                    (w_k64 > (64'd1 << ADDR_W));

  il_read_addr #(
    .COLS   (COLS),
    .ADDR_W (ADDR_W),
    .ROWS_W (ROWS_W),
    .COL_W  (COL_W)
  ) u_read_addr (
    .col  (r_col),
    .row  (r_row),
    .mode (r_mode),
    .k_pi (r_k),
    .addr (w_rd_addr)
  );

  assign w_rd_dummy = KW'(w_rd_addr) < r_nd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_k     <= '0;
      r_nd    <= '0;
      r_rows  <= '0;
      r_mode  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      if (r_state == S_IDLE && start) begin
        r_k    <= KW'(w_k64);
        r_nd   <= KW'(w_k64 - 64'(d_len));
        r_rows <= rows;
        r_mode <= mode;
        r_err  <= w_reject;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_adv       = 1'b0;
    addr        = '0;
    addr_valid  = 1'b0;
    phase       = c_ph_idle;
    is_dummy    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_cnt_nxt = '0;
          w_col_nxt = '0;
          w_row_nxt = '0;
          if (w_reject)                   w_state_nxt = S_DONE;
          else if (w_k64 == 64'(d_len))   w_state_nxt = S_WRITE;
          else                            w_state_nxt = S_DUMMY;
        end
      end

      // DUMMY and WRITE share one linear counter; the phase flips at ND.
      S_DUMMY, S_WRITE: begin
        addr       = r_cnt;
        addr_valid = 1'b1;
        phase      = (r_state == S_DUMMY) ? c_ph_dummy : c_ph_write;
        is_dummy   = (r_state == S_DUMMY);
        if (addr_ready) begin
          if (KW'(r_cnt) == r_k - KW'(1)) begin
            w_state_nxt = S_READ;
          end else begin
            w_cnt_nxt   = r_cnt + ADDR_W'(1);
            w_state_nxt = ((KW'(r_cnt) + KW'(1)) < r_nd) ? S_DUMMY : S_WRITE;
          end
        end
      end

      S_READ: begin
        addr     = w_rd_addr;
        phase    = c_ph_read;
        is_dummy = w_rd_dummy;
`ifdef IL_SKIP_DUMMY_EN
        addr_valid = !w_rd_dummy;
        w_adv      = w_rd_dummy || addr_ready;
`else
        addr_valid = 1'b1;
        w_adv      = addr_ready;
`endif
        if (w_adv) begin
          if (r_row == r_rows - ROWS_W'(1)) begin
            w_row_nxt = '0;
            if (r_col == COL_W'(COLS - 1)) w_state_nxt = S_DONE;
            else                           w_col_nxt   = r_col + COL_W'(1);
          end else begin
            w_row_nxt = r_row + ROWS_W'(1);
          end
        end
      end

      S_DONE: begin
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = S_IDLE;
      end

      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_subblock_interleaver_addr_gen.sv
// +----------------------------------------------------------------------------+
// | tb_subblock_interleaver_addr_gen                                           |
// | Scoreboard bench for the interleaver address generator (COLS = 32).        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_subblock_interleaver_addr_gen;

  logic        clk = 1'b0;
  logic        rst, start, mode, addr_ready;
  logic [11:0] d_len, addr;
  logic [6:0]  rows;
  logic        addr_valid, is_dummy, busy, done, err;
  logic [1:0]  phase;

  typedef struct packed {
    logic [11:0] a;
    logic        dm;
    logic [1:0]  ph;
  } ent_t;

  ent_t q_exp[$];
  ent_t q_log[$];
  int   q_rd[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  subblock_interleaver_addr_gen #(
    .COLS   (32),
    .ADDR_W (12),
    .ROWS_W (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .d_len      (d_len),
    .rows       (rows),
    .mode       (mode),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .phase      (phase),
    .is_dummy   (is_dummy),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  function automatic int rev5(int j);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((j >> b) & 1) r |= 1 << (4 - b);
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_frame(int d, int r, int m);
    int   k  = r * 32;
    int   nd = k - d;
    ent_t e;
    for (int a = 0; a < k; a++) begin
      e.a = 12'(a); e.dm = (a < nd); e.ph = (a < nd) ? 2'd1 : 2'd2;
      q_exp.push_back(e);
    end
    for (int j = 0; j < 32; j++) begin
      for (int i = 0; i < r; i++) begin
        int a = rev5(j) + 32 * i + m;
        if (a >= k) a -= k;
`ifdef IL_SKIP_DUMMY_EN
        if (a >= nd) begin
          e.a = 12'(a); e.dm = 1'b0; e.ph = 2'd3;
          q_exp.push_back(e);
        end
`else
        e.a = 12'(a); e.dm = (a < nd); e.ph = 2'd3;
        q_exp.push_back(e);
`endif
      end
    end
  endtask

  // Monitor: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && addr_valid && addr_ready) begin
      ent_t got;
      got = {addr, is_dummy, phase};
      q_log.push_back(got);
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL scoreboard unexpected addr=%0d dummy=%0d phase=%0d", addr, is_dummy, phase);
      end else begin
        ent_t e;
        e = q_exp.pop_front();
        if (got != e) begin
          errors++;
          $display("FAIL scoreboard addr=%0d dummy=%0d phase=%0d expected addr=%0d dummy=%0d phase=%0d",
                   addr, is_dummy, phase, e.a, e.dm, e.ph);
        end
      end
    end
  end

  task automatic start_frame(int d, int r, int m);
    @(posedge clk); #1;
    d_len = 12'(d); rows = 7'(r); mode = m[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int exp_err);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done seen"}, done, 1);
    chk({name, " err"}, err, exp_err);
    chk({name, " pending"}, q_exp.size(), 0);
    @(negedge clk);
    chk({name, " idle after done"}, busy, 0);
  endtask

  task automatic wait_read(string name);
    int n = 0;
    while (phase != 2'd3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, " reached read"}, phase, 3);
  endtask

  task automatic build_reads();
    q_rd.delete();
    foreach (q_log[i]) if (q_log[i].ph == 2'd3) q_rd.push_back(int'(q_log[i].a));
  endtask

  task automatic chk_idle_outputs(string name);
    chk({name, " addr"}, addr, 0);
    chk({name, " addr_valid"}, addr_valid, 0);
    chk({name, " phase"}, phase, 0);
    chk({name, " is_dummy"}, is_dummy, 0);
    chk({name, " busy"}, busy, 0);
    chk({name, " done"}, done, 0);
    chk({name, " err"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [11:0] a0;
    logic        d0;
    rst = 1'b1; start = 1'b0; d_len = '0; rows = '0; mode = 1'b0; addr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    // R=1, D=30, mode 0: two dummies, then 30 writes, then 32 reads
    q_log.delete();
    push_frame(30, 1, 0);
    start_frame(30, 1, 0);
    chk("t1 valid after start", addr_valid, 1);
    chk("t1 first phase", phase, 1);
    chk("t1 busy", busy, 1);
    wait_done("t1", 0);
    build_reads();
`ifdef IL_SKIP_DUMMY_EN
    chk("t1 read count", q_rd.size(), 30);
    if (q_rd.size() == 30) begin
      chk("t1 read0", q_rd[0], 16);
      chk("t1 read1", q_rd[1], 8);
      chk("t1 read last", q_rd[29], 31);
    end
`else
    chk("t1 read count", q_rd.size(), 32);
    if (q_rd.size() == 32) begin
      chk("t1 read0", q_rd[0], 0);
      chk("t1 read1", q_rd[1], 16);
      chk("t1 read2", q_rd[2], 8);
      chk("t1 read3", q_rd[3], 24);
      chk("t1 read4", q_rd[4], 4);
      chk("t1 read last", q_rd[31], 31);
    end
`endif

    // R=2, D=64, mode 0: no dummy phase
    q_log.delete();
    push_frame(64, 2, 0);
    start_frame(64, 2, 0);
    chk("t2 first phase", phase, 2);
    wait_done("t2", 0);
    build_reads();
    chk("t2 read count", q_rd.size(), 64);
    if (q_rd.size() == 64) begin
      chk("t2 read0", q_rd[0], 0);
      chk("t2 read1", q_rd[1], 32);
      chk("t2 read2", q_rd[2], 16);
      chk("t2 read3", q_rd[3], 48);
      chk("t2 read62", q_rd[62], 31);
      chk("t2 read63", q_rd[63], 63);
    end

    // R=2, D=64, mode 1: offset with wrap at the end
    q_log.delete();
    push_frame(64, 2, 1);
    start_frame(64, 2, 1);
    wait_done("t3", 0);
    build_reads();
    chk("t3 read count", q_rd.size(), 64);
    if (q_rd.size() == 64) begin
      chk("t3 read0", q_rd[0], 1);
      chk("t3 read1", q_rd[1], 33);
      chk("t3 read2", q_rd[2], 17);
      chk("t3 read3", q_rd[3], 49);
      chk("t3 read62", q_rd[62], 32);
      chk("t3 read63", q_rd[63], 0);
    end

    // Stall mid-READ for 3 cycles; a start pulse while busy must be ignored
    push_frame(30, 1, 0);
    start_frame(30, 1, 0);
    wait_read("t4");
    repeat (4) @(posedge clk);
    #1;
    addr_ready = 1'b0;
    start = 1'b1; d_len = 12'd64; rows = 7'd2;
    @(negedge clk);
    a0 = addr; d0 = is_dummy;
    chk("t4 stall valid", addr_valid, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t4 stall addr c2", addr, a0);
    chk("t4 stall dummy c2", is_dummy, d0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4 stall addr c3", addr, a0);
    chk("t4 stall dummy c3", is_dummy, d0);
    chk("t4 stall phase", phase, 3);
    @(posedge clk); #1;
    addr_ready = 1'b1;
    wait_done("t4", 0);

    // D=70 > K_pi=64: rejected, done+err in the cycle after start
    start_frame(70, 2, 0);
    chk("t5 done", done, 1);
    chk("t5 err", err, 1);
    chk("t5 addr_valid", addr_valid, 0);
    chk("t5 busy", busy, 1);
    @(posedge clk); #1;
    chk("t5 done cleared", done, 0);
    chk("t5 busy cleared", busy, 0);

    // R=0 is rejected too
    start_frame(5, 0, 0);
    chk("t6 err", err, 1);
    chk("t6 done", done, 1);

    // Reset mid-READ
    push_frame(64, 2, 0);
    start_frame(64, 2, 0);
    wait_read("t7");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("t7 reset");
    q_exp.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t7 stays idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/subblock_interleaver_addr_gen.md
SUBBLOCK_INTERLEAVER_ADDR_GEN -- requirements
Module: subblock_interleaver_addr_gen

Interface
REQ-001 SHALL have parameter COLS, 32, interleaver column count; power of two, 4..64.
REQ-002 SHALL have parameter ADDR_W, 12, RAM address width.
REQ-003 SHALL have parameter ROWS_W, 7, width of the row-count input.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to run a frame.
REQ-007 SHALL have port d_len, input, ADDR_W, data item count D.
REQ-008 SHALL have port rows, input, ROWS_W, row count R.
REQ-009 SHALL have port mode, input, 1, read offset select: 0 = none, 1 = +1 modulo K_pi.
REQ-010 SHALL have port addr, output, ADDR_W, RAM address.
REQ-011 SHALL have port addr_valid, output, 1, addr is meaningful.
REQ-012 SHALL have port addr_ready, input, 1, consumer accepts addr.
REQ-013 SHALL have port phase, output, 2, 0 = IDLE, 1 = DUMMY, 2 = WRITE, 3 = READ.
REQ-014 SHALL have port is_dummy, output, 1, current addr holds a dummy entry.
REQ-015 SHALL have ports busy, done and err, output, 1 each: busy = frame running; done = one-cycle end pulse; err = frame rejected, valid with done.

Function
REQ-016 SHALL run the states IDLE -> DUMMY -> WRITE -> READ -> DONE -> IDLE.
REQ-017 SHALL, in IDLE on start, latch D, R and mode, then compute K_pi = R*COLS and ND = K_pi - D.
REQ-018 SHALL, if R == 0, D == 0 or D > K_pi, go to DONE with err=1 and emit no addresses.
REQ-019 SHALL have addr_valid=1 in the cycle after start is accepted.
REQ-020 SHALL, in DUMMY, emit 0..ND-1 with is_dummy=1, and SHALL bypass DUMMY when ND == 0.
REQ-021 SHALL, in WRITE, emit ND..K_pi-1 with is_dummy=0.
REQ-022 SHALL, in READ, emit for column j = 0..COLS-1 and, inside it, row i = 0..R-1 the value a = bitrev(j) + COLS*i, plus mode, reduced modulo K_pi.
REQ-023 SHALL set is_dummy=1 in READ when a < ND.
REQ-024 SHALL advance addr only on addr_valid && addr_ready; otherwise addr, phase and is_dummy SHALL hold stable.
REQ-025 SHALL insert no bubble cycles between phases.
REQ-026 SHALL pulse done one cycle after the last READ handshake, then return to IDLE.
REQ-027 SHALL hold busy=1 from start acceptance through DONE inclusive.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL compute the offset sum in ADDR_W+1 bits and subtract K_pi when the sum is >= K_pi.
REQ-030 SHALL hold addr_valid=0 in IDLE and DONE.

Reset
REQ-031 SHALL, on rst=1 at a clock edge (including mid-frame), go to IDLE with addr=0, addr_valid=0, phase=0, is_dummy=0, busy=0, done=0 and err=0, and clear all counters.

Configuration
REQ-032 SHALL, with IL_SKIP_DUMMY_EN defined, skip READ positions where a < ND: one internal cycle each with addr_valid=0, never presented.
REQ-033 SHALL, without IL_SKIP_DUMMY_EN, present every READ position, flagging dummy positions with is_dummy=1.

Structure
REQ-034 SHALL place the state enum, the phase encoding constants and the bitrev function in shared package il_pkg.
REQ-035 SHALL put the read-address computation (bit-reverse, row stride, offset, modulo) in sub-module il_read_addr.

Verification
REQ-036 SHALL cover COLS=32, R=1, D=30, mode 0: DUMMY emits 0,1; WRITE emits 2..31; READ emits 0,16,8,24,4,...,31 (32 addresses), with 0 and 1 flagged is_dummy; then a done pulse.
REQ-037 SHALL cover R=2, D=64, mode 0: READ emits 0,32,16,48,8,40,...,31,63; no DUMMY phase.
REQ-038 SHALL cover R=2, D=64, mode 1: READ emits 1,33,17,49,...; the final pair is 32,0 (wrap).
REQ-039 SHALL cover addr_ready held low for 3 cycles mid-READ: addr and is_dummy stay constant, and the sequence resumes with no address lost or repeated.
REQ-040 SHALL cover D=70, R=2: err=1 with done in the second cycle and no addr_valid; separately, rst asserted mid-READ gives IDLE with all outputs 0 the next cycle.
REQ-041 SHALL cover IL_SKIP_DUMMY_EN, R=1, D=30, mode 0: READ presents 30 addresses, excluding 0 and 1.
